fetch_stage: RTL

- IF stage of the 5-stage MIPS pipeline. Owns the PC and the IF/ID pipeline register.
- Drives the instruction memory address and registers the returned word into IF/ID.
- Honours stall requests from the hazard-detection unit and redirects (taken branch / jump) from later stages.
- Sits directly upstream of decode and wraps the combinational instruction memory.

---
 rtl/fetch_stage.sv | 66 ++++++
 1 files changed

// File: rtl/fetch_stage.sv
// IF stage: owns the PC and the IF/ID register. Optional FETCH_PERF_CNT_EN adds stall/squash counters.
// Latency: imem_addr is combinational from pc; the word fetched at pc appears on if_id_* one edge later.
// Backpressure: stall holds pc and IF/ID; redirect overrides stall, loads the target and inserts a bubble.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] squash_count,
`endif
    output logic        if_id_valid
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        unused_target_lsbs;

    assign imem_addr          = pc;
    assign pc_plus4           = pc + 32'd4;
    assign unused_target_lsbs = ^redirect_target[1:0];

    // Redirect belongs to an older instruction, so it wins over a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            if_id_instr    <= NOP_WORD;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
        end else if (redirect) begin
            pc             <= {redirect_target[31:2], 2'b00};
            if_id_instr    <= NOP_WORD;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
        end else if (!stall) begin
            pc             <= pc_plus4;
            if_id_instr    <= imem_rdata;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= 32'd0;
            squash_count <= 32'd0;
        end else begin
            if (redirect && squash_count != 32'hFFFF_FFFF)
                squash_count <= squash_count + 32'd1;
            if (stall && !redirect && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
